// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit state per clock
// through shared inverse S-box lookups, with valid/ready handshakes on both sides.
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] inv_subbed_state,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for an input state
  // BUSY  | substituting one byte group per clock in the working register
  // DONE  | result presented, held until out_ready

  localparam int NUM_GROUPS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } st_t;

  st_t              cur_st, nxt_st;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     work;
  logic [127:0]     sub_work;
  logic [127:0]     res;
  logic             accept;
  logic             last_grp;

  assign in_ready         = (cur_st == IDLE) || ((cur_st == DONE) && out_ready);
  assign accept           = in_valid && in_ready;
  assign last_grp         = (cnt == CNT_W'(NUM_GROUPS - 1));
  assign out_valid        = (cur_st == DONE);
  assign busy             = (cur_st == BUSY);
  assign inv_subbed_state = res;

  // Replace the current byte group of the working register with its InvSbox values.
  always_comb begin
    int k;
    sub_work = work;
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      k = int'(cnt) * BYTES_PER_CYCLE + g;
      sub_work[127 - 8*k -: 8] = INV_SBOX[work[127 - 8*k -: 8]];
    end
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      IDLE:    if (accept) nxt_st = BUSY;
      BUSY:    if (last_grp) nxt_st = DONE;
      DONE:    if (out_ready) nxt_st = accept ? BUSY : IDLE;
      default: nxt_st = IDLE;
    endcase
  end

  // The result register is loaded only on the final group, so it holds steady between results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_st <= IDLE;
      cnt    <= '0;
      work   <= '0;
      res    <= '0;
    end else begin
      cur_st <= nxt_st;
      if (accept) begin
        work <= state;
        cnt  <= '0;
      end else if (cur_st == BUSY) begin
        work <= sub_work;
        cnt  <= cnt + CNT_W'(1);
        if (last_grp) res <= sub_work;
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed and round-trip checks of inv_sub_bytes_seq at BYTES_PER_CYCLE = 4, 1 and 16.
module tb_inv_sub_bytes_seq;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_valid_alt = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state = '0;

  logic         in_ready, out_valid, busy;
  logic [127:0] inv_subbed_state;
  logic         in_ready1, out_valid1, busy1;
  logic [127:0] res1;
  logic         in_ready16, out_valid16, busy16;
  logic [127:0] res16;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .state(state),
    .out_valid(out_valid), .out_ready(out_ready), .inv_subbed_state(inv_subbed_state), .busy(busy)
  );

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_alt), .in_ready(in_ready1), .state(state),
    .out_valid(out_valid1), .out_ready(out_ready), .inv_subbed_state(res1), .busy(busy1)
  );

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_alt), .in_ready(in_ready16), .state(state),
    .out_valid(out_valid16), .out_ready(out_ready), .inv_subbed_state(res16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[127 - 8*k -: 8] = SBOX[x[127 - 8*k -: 8]];
    return y;
  endfunction

  task automatic wait_main(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_main();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_main(input logic [127:0] vin, input logic [127:0] vexp, input string tag);
    int lat;
    state    = vin;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    state    = ~vin;
    wait_main(lat);
    check({tag, "_lat"}, 128'(lat), 128'(4));
    check({tag, "_data"}, inv_subbed_state, vexp);
    pop_main();
  endtask

  task automatic run_alt(input logic [127:0] vin, input logic [127:0] vexp, input string tag);
    int n, l1, l16;
    state        = vin;
    in_valid_alt = 1'b1;
    @(negedge clk);
    in_valid_alt = 1'b0;
    state        = ~vin;
    n = 0; l1 = 0; l16 = 0;
    while ((!out_valid1 || !out_valid16) && n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid1 && l1 == 0) l1 = n;
      if (out_valid16 && l16 == 0) l16 = n;
    end
    check({tag, "_lat_bpc1"}, 128'(l1), 128'(16));
    check({tag, "_lat_bpc16"}, 128'(l16), 128'(1));
    check({tag, "_data_bpc1"}, res1, vexp);
    check({tag, "_data_bpc16"}, res16, vexp);
    pop_main();
  endtask

  initial begin
    logic [127:0] kv_in, kv_out, x;
    int lat, stall;
    kv_in  = 128'h637c777bf26b6fc53001672bfed7ab76;
    kv_out = 128'h000102030405060708090a0b0c0d0e0f;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_data", inv_subbed_state, 128'h0);
    check("rst_out_valid_bpc1", 128'(out_valid1), 128'(0));
    check("rst_data_bpc16", res16, 128'h0);

    // known vector, with the input changed mid-operation to confirm it is ignored
    state    = kv_in;
    in_valid = 1'b1;
    @(negedge clk);
    state    = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    check("kv_busy", 128'(busy), 128'(1));
    check("kv_in_ready_busy", 128'(in_ready), 128'(0));
    wait_main(lat);
    in_valid = 1'b0;
    check("kv_lat", 128'(lat), 128'(4));
    check("kv_data", inv_subbed_state, kv_out);
    pop_main();
    check("kv_idle_after_pop", 128'(out_valid), 128'(0));

    run_main({16{8'h00}}, {16{8'h52}}, "zero");
    run_main({16{8'h63}}, {16{8'h00}}, "c63");
    run_alt({16{8'h00}}, {16{8'h52}}, "zero");
    run_alt({16{8'h63}}, {16{8'h00}}, "c63");
    run_alt(kv_in, kv_out, "kv");

    // backpressure then back-to-back accept
    state    = kv_in;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_main(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_data", inv_subbed_state, kv_out);
    end
    state     = {16{8'h16}};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_busy", 128'(busy), 128'(1));
    check("b2b_out_valid", 128'(out_valid), 128'(0));
    wait_main(lat);
    check("b2b_lat", 128'(lat), 128'(4));
    check("b2b_data", inv_subbed_state, {16{8'hff}});
    pop_main();

    // reset two cycles into BUSY
    state    = kv_in;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_data", inv_subbed_state, 128'h0);
    repeat (6) @(negedge clk);
    check("mid_rst_no_stale_valid", 128'(out_valid), 128'(0));
    run_main({16{8'hed}}, {16{8'h53}}, "ced");

    // round trip through the forward S-box with random output stalls
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      state    = sub_bytes(x);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_main(lat);
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      check("rt_data", inv_subbed_state, x);
      pop_main();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Iterative AES InvSubBytes engine for the decryption datapath; the inverse of the combinational Sub_Bytes stage.
- Accepts one 128-bit state and applies the FIPS-197 inverse S-box to every byte, BYTES_PER_CYCLE bytes per clock, using a shared inverse S-box lookup.
- Sits between the decryption InvShiftRows stage and AddRoundKey.
- Uses a valid/ready handshake on both sides.

Parameters:
- BYTES_PER_CYCLE, 4: bytes substituted per clock. Legal values are 1, 2, 4, 8 and 16; any other value is a synthesis error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  state is offered on state.
- in_ready  output  1  block can accept a state this cycle.
- state  input  128  input state; byte k = state[127-8k -: 8], k = 0..15.
- out_valid  output  1  inv_subbed_state holds a result.
- out_ready  input  1  downstream accepts the result.
- inv_subbed_state  output  128  result; byte k = InvSbox(input byte k).
- busy  output  1  high while in BUSY.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the clk rising edge. The polarity and synchronicity are fixed.
- Reset values: state machine in IDLE, in_ready=1, out_valid=0, busy=0, inv_subbed_state=0, byte counter=0. Reset mid-operation discards the state in flight; no out_valid is produced for it.
- State machine:
  - IDLE → BUSY on in_valid. The state is captured into a 128-bit working register and the counter is cleared.
  - BUSY: each cycle, bytes cnt*BPC .. cnt*BPC+BPC-1 of the working register are replaced in place by their InvSbox values, and cnt increments. When the last group is written, go to DONE.
  - DONE: out_valid=1 and inv_subbed_state = working register, held stable until accepted. DONE → IDLE on out_ready.
- Back-to-back accept: in_ready = (IDLE) or (DONE and out_ready). If in_valid and out_ready are both high in DONE, the result is delivered and the new state is captured in the same edge; the next state is BUSY.
- Latency: a state accepted at edge T gives out_valid=1 at edge T+16/BPC. BPC=4 gives 4 cycles; BPC=16 gives 1 cycle; BPC=1 gives 16 cycles.
- Counter: width is clog2(16/BPC), minimum 1 bit. It wraps to 0 on entry to BUSY and is not used outside BUSY.
- Input stability: state is sampled only on the accept edge. Changes to in_valid or state while in BUSY are ignored; in_ready=0 throughout BUSY.
- Output stability: while out_valid=1 and out_ready=0, inv_subbed_state and out_valid must not change. Between results, inv_subbed_state keeps its last value.
- Inverse S-box: the standard 256-entry FIPS-197 table, purely combinational, with BPC instances. Anchor values: InvSbox(00)=52, InvSbox(63)=00, InvSbox(7C)=01, InvSbox(16)=FF, InvSbox(ED)=53.
- Round trip: for any X, feeding Sub_Bytes(X) into this block must return X.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles → in_ready=1, out_valid=0, busy=0, inv_subbed_state=0.
- Known vector, BPC=4: state=637C777BF26B6FC53001672BFED7AB76 → out_valid exactly 4 cycles after accept, inv_subbed_state=000102030405060708090A0B0C0D0E0F.
- Constant vectors: all-00 → all-52. All-63 → all-00. Repeat at BPC=1, expecting a 16-cycle latency, and at BPC=16, expecting a 1-cycle latency.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE → output stable and in_ready=0.
  - Raise out_ready together with in_valid and a new state=16161616…16 → first result handed off and second accepted in the same cycle.
  - Second result = all-FF.
- Reset mid-operation: assert rst_n=0 two cycles into BUSY → next cycle in IDLE with out_valid=0. A new state=EDEDED…ED then yields all-53 with no stale bytes.
- Random round trip: 1000 random X driven through Sub_Bytes then this block, with random out_ready stalls → output equals X every time.
